// File: rtl/tmds_decoder.sv
// tmds_decoder: one TMDS receive channel.
// Word alignment, video/control/TERC4 decode, disparity check.
module tmds_decoder #(
  parameter int LOCK_CTL       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16,
  parameter int DISP_LIMIT     = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [9:0]  SYMBOL,
  output logic        BITSLIP,
  output logic        LOCKED,
  output logic [7:0]  DATA,
  output logic [1:0]  C,
  output logic        CTL,
  output logic [3:0]  AUX,
  output logic        TERC4_HIT,
  output logic        ERR,
  output logic [15:0] ERR_CNT
);

  localparam int TW = $clog2(SEARCH_TIMEOUT);
  localparam int RW = $clog2(LOCK_CTL + 1);
  localparam logic [TW-1:0] T_END = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] W_END = TW'(SLIP_WAIT - 1);
  localparam logic [RW-1:0] R_MAX = RW'(LOCK_CTL);
  localparam logic [RW-1:0] R_HIT = RW'(LOCK_CTL - 1);
  localparam logic signed [7:0] LIM = 8'(DISP_LIMIT);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SLIP,
    S_WAIT,
    S_LOCK
  } state_t;

  state_t state_q, state_d;

  logic [9:0]  sym_q;
  logic [9:0]  q_w;
  logic [7:0]  data_q, data_d;
  logic [1:0]  c_q, c_d;
  logic [3:0]  aux_q, aux_d;
  logic        ctl_q, is_ctl;
  logic        hit_q, is_terc;
  logic        err_q, err_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic signed [6:0] disp_q, disp_d;
  logic signed [7:0] sum_w, disp_x;
  logic [3:0]  ones_w;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] run_q, run_d, run_step;
  logic        reach;
  logic        bslip_q, lock_q;

  // Video decode: undo optional inversion, then XOR/XNOR chain
  always_comb begin
    q_w = sym_q;
    if (q_w[9]) q_w[7:0] = ~q_w[7:0];
    data_d[0] = q_w[0];
    for (int i = 1; i < 8; i++) begin
      data_d[i] = q_w[8] ? (q_w[i] ^ q_w[i-1])
                         : ~(q_w[i] ^ q_w[i-1]);
    end
  end

  // Control token match; C holds on a miss
  always_comb begin
    is_ctl = 1'b1;
    c_d    = c_q;
    unique case (sym_q)
      10'b1101010100: c_d = 2'b00;
      10'b0010101011: c_d = 2'b01;
      10'b0101010100: c_d = 2'b10;
      10'b1010101011: c_d = 2'b11;
      default:        is_ctl = 1'b0;
    endcase
  end

  // TERC4 match; AUX holds on a miss
  always_comb begin
    is_terc = 1'b1;
    aux_d   = aux_q;
    unique case (sym_q)
      10'b1010011100: aux_d = 4'h0;
      10'b1001100011: aux_d = 4'h1;
      10'b1011100100: aux_d = 4'h2;
      10'b1011100010: aux_d = 4'h3;
      10'b0101110001: aux_d = 4'h4;
      10'b0100011110: aux_d = 4'h5;
      10'b0110001110: aux_d = 4'h6;
      10'b0100111100: aux_d = 4'h7;
      10'b1011001100: aux_d = 4'h8;
      10'b0100111001: aux_d = 4'h9;
      10'b0110011100: aux_d = 4'hA;
      10'b1011000110: aux_d = 4'hB;
      10'b1010001110: aux_d = 4'hC;
      10'b1001110001: aux_d = 4'hD;
      10'b0101100011: aux_d = 4'hE;
      10'b1011000011: aux_d = 4'hF;
      default:        is_terc = 1'b0;
    endcase
  end

  // Saturating running disparity and error flag/counter
  always_comb begin
    ones_w = 4'($countones(sym_q));
    sum_w  = $signed({disp_q[6], disp_q})
           + $signed({4'b0000, ones_w}) - 8'sd5;
    disp_d = disp_q;
    if (is_ctl) begin
      disp_d = '0;
    end else if (!is_terc) begin
      if (sum_w > 8'sd63)       disp_d = 7'sd63;
      else if (sum_w < -8'sd63) disp_d = -7'sd63;
      else                      disp_d = sum_w[6:0];
    end
    disp_x = {disp_d[6], disp_d};
    err_d  = lock_q && !is_ctl && !is_terc
          && (disp_x > LIM || disp_x < -LIM);
    ecnt_d = ecnt_q;
    if (err_d && ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
  end

  // Alignment FSM: next state, timer and control-run counter
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    run_d    = run_q;
    run_step = '0;
    if (is_ctl) begin
      run_step = (run_q == R_MAX) ? run_q : run_q + RW'(1);
    end
    reach = is_ctl && (run_q == R_HIT);
    unique case (state_q)
      S_SEARCH: begin
        run_d = run_step;
        if (reach) begin
          state_d = S_LOCK;
          timer_d = '0;
        end else if (timer_q == T_END) begin
          state_d = S_SLIP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_SLIP: begin
        state_d = S_WAIT;
        run_d   = '0;
        timer_d = '0;
      end
      S_WAIT: begin
        run_d = '0;
        if (timer_q == W_END) begin
          state_d = S_SEARCH;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_LOCK: begin
        run_d = run_step;
        if (reach) begin
          timer_d = '0;
        end else if (timer_q == T_END) begin
          state_d = S_SEARCH;
          timer_d = '0;
          run_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  // Two-stage symbol/decode pipeline
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sym_q  <= '0;
      data_q <= '0;
      c_q    <= '0;
      ctl_q  <= 1'b0;
      aux_q  <= '0;
      hit_q  <= 1'b0;
      err_q  <= 1'b0;
      ecnt_q <= '0;
      disp_q <= '0;
    end else begin
      sym_q  <= SYMBOL;
      data_q <= data_d;
      c_q    <= c_d;
      ctl_q  <= is_ctl;
      aux_q  <= aux_d;
      hit_q  <= is_terc;
      err_q  <= err_d;
      ecnt_q <= ecnt_d;
      disp_q <= disp_d;
    end
  end

  // FSM state with registered, glitch-free status outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_SEARCH;
      timer_q <= '0;
      run_q   <= '0;
      bslip_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      run_q   <= run_d;
      bslip_q <= (state_d == S_SLIP);
      lock_q  <= (state_d == S_LOCK);
    end
  end

  assign BITSLIP   = bslip_q;
  assign LOCKED    = lock_q;
  assign DATA      = data_q;
  assign C         = c_q;
  assign CTL       = ctl_q;
  assign AUX       = aux_q;
  assign TERC4_HIT = hit_q;
  assign ERR       = err_q;
  assign ERR_CNT   = ecnt_q;

endmodule
